udt_rx_handshake_filter: RTL and testbench



---
 rtl/udt_rx_handshake_filter.sv | 238 +++++++++++++++++++++++
 tb/tb_udt_rx_handshake_filter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udt_rx_handshake_filter.sv
// udt_rx_handshake_filter
// Receive-side classifier ahead of the listen stage. Well-formed handshake
// control packets (control bit set, type 0, exactly HS_BEATS full beats) are
// buffered whole and replayed on handshake_*. Malformed handshakes are
// discarded and counted. Every other packet goes through a one-deep register
// slice to data_*.

module udt_rx_handshake_filter #(
    parameter int HS_BEATS = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             core_rst_n,

    input  logic [63:0]      s_tdata,
    input  logic [7:0]       s_tkeep,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,

    output logic [63:0]      handshake_tdata,
    output logic [7:0]       handshake_tkeep,
    output logic             handshake_tvalid,
    output logic             handshake_tlast,
    input  logic             handshake_tready,

    output logic [63:0]      data_tdata,
    output logic [7:0]       data_tkeep,
    output logic             data_tvalid,
    output logic             data_tlast,
    input  logic             data_tready,

    output logic [CNT_W-1:0] hs_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int               IDX_W    = (HS_BEATS > 1) ? $clog2(HS_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HS_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DROP,
        ST_EMIT,
        ST_PASS
    } state_t;

    state_t           state_q;
    logic [63:0]      hs_buf_q [HS_BEATS];
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] rd_q;
    logic [IDX_W-1:0] rd_d;
    logic             keep_ok_q;

    logic [63:0]      hs_tdata_q;
    logic [7:0]       hs_tkeep_q;
    logic             hs_tvalid_q;
    logic             hs_tlast_q;

    logic [63:0]      data_tdata_q;
    logic [7:0]       data_tkeep_q;
    logic             data_tvalid_q;
    logic             data_tlast_q;

    logic [CNT_W-1:0] hs_count_q;
    logic [CNT_W-1:0] drop_count_q;
    logic [CNT_W-1:0] hs_count_d;
    logic [CNT_W-1:0] drop_count_d;

    logic             s_ready;
    logic             s_fire;
    logic             is_hs;
    logic             keep_full;
    logic             hs_fire;
    logic             data_load;

    // A first beat is a handshake when it is a control packet of type 0.
    assign is_hs     = s_tdata[63] && (s_tdata[62:48] == 15'h0000);
    assign keep_full = (s_tkeep == 8'hFF);
    assign s_fire    = s_tvalid && s_ready;
    assign hs_fire   = hs_tvalid_q && handshake_tready;
    assign rd_d      = rd_q + 1'b1;

    // The slice reloads on every non-handshake beat taken in IDLE or PASS.
    assign data_load = s_fire &&
                       (((state_q == ST_IDLE) && !is_hs) || (state_q == ST_PASS));

    // Counters stick at all-ones instead of wrapping.
    assign hs_count_d   = (hs_count_q == CNT_MAX)   ? hs_count_q   : hs_count_q + 1'b1;
    assign drop_count_d = (drop_count_q == CNT_MAX) ? drop_count_q : drop_count_q + 1'b1;

    // Input backpressure: the slice gates IDLE/PASS, collection and discard
    // always accept, and replay blocks the input entirely.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            ST_IDLE,
            ST_PASS:    s_ready = !data_tvalid_q || data_tready;
            ST_COLLECT,
            ST_DROP:    s_ready = 1'b1;
            default:    s_ready = 1'b0;
        endcase
        if (!core_rst_n) begin
            s_ready = 1'b0;
        end
    end

    // Classification FSM with the handshake buffer, replay outputs and counters.
    always_ff @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rd_q         <= '0;
            keep_ok_q    <= 1'b0;
            hs_tdata_q   <= '0;
            hs_tkeep_q   <= '0;
            hs_tvalid_q  <= 1'b0;
            hs_tlast_q   <= 1'b0;
            hs_count_q   <= '0;
            drop_count_q <= '0;
            for (int i = 0; i < HS_BEATS; i++) begin
                hs_buf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_fire) begin
                        if (is_hs) begin
                            if (s_tlast) begin
                                drop_count_q <= drop_count_d;
                            end else begin
                                hs_buf_q[0] <= s_tdata;
                                cnt_q       <= IDX_W'(1);
                                keep_ok_q   <= keep_full;
                                state_q     <= ST_COLLECT;
                            end
                        end else if (!s_tlast) begin
                            state_q <= ST_PASS;
                        end
                    end
                end

                ST_COLLECT: begin
                    if (s_fire) begin
                        hs_buf_q[cnt_q] <= s_tdata;
                        keep_ok_q       <= keep_ok_q && keep_full;
                        if (s_tlast) begin
                            cnt_q <= '0;
                            if ((cnt_q == LAST_IDX) && keep_ok_q && keep_full) begin
                                rd_q        <= '0;
                                hs_tdata_q  <= hs_buf_q[0];
                                hs_tkeep_q  <= 8'hFF;
                                hs_tvalid_q <= 1'b1;
                                hs_tlast_q  <= 1'b0;
                                state_q     <= ST_EMIT;
                            end else begin
                                drop_count_q <= drop_count_d;
                                state_q      <= ST_IDLE;
                            end
                        end else if (cnt_q == LAST_IDX) begin
                            cnt_q        <= '0;
                            drop_count_q <= drop_count_d;
                            state_q      <= ST_DROP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                ST_DROP: begin
                    if (s_fire && s_tlast) begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_EMIT: begin
                    if (hs_fire) begin
                        if (rd_q == LAST_IDX) begin
                            rd_q        <= '0;
                            hs_tdata_q  <= '0;
                            hs_tkeep_q  <= '0;
                            hs_tvalid_q <= 1'b0;
                            hs_tlast_q  <= 1'b0;
                            hs_count_q  <= hs_count_d;
                            state_q     <= ST_IDLE;
                        end else begin
                            rd_q       <= rd_d;
                            hs_tdata_q <= hs_buf_q[rd_d];
                            hs_tlast_q <= (rd_d == LAST_IDX);
                        end
                    end
                end

                ST_PASS: begin
                    if (s_fire && s_tlast) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // One-deep pass-through slice; contents hold while data_tready is low.
    always_ff @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            data_tdata_q  <= '0;
            data_tkeep_q  <= '0;
            data_tvalid_q <= 1'b0;
            data_tlast_q  <= 1'b0;
        end else if (data_load) begin
            data_tdata_q  <= s_tdata;
            data_tkeep_q  <= s_tkeep;
            data_tvalid_q <= 1'b1;
            data_tlast_q  <= s_tlast;
        end else if (data_tready) begin
            data_tvalid_q <= 1'b0;
            data_tlast_q  <= 1'b0;
        end
    end

    assign s_tready         = s_ready;
    assign handshake_tdata  = hs_tdata_q;
    assign handshake_tkeep  = hs_tkeep_q;
    assign handshake_tvalid = hs_tvalid_q;
    assign handshake_tlast  = hs_tlast_q;
    assign data_tdata       = data_tdata_q;
    assign data_tkeep       = data_tkeep_q;
    assign data_tvalid      = data_tvalid_q;
    assign data_tlast       = data_tlast_q;
    assign hs_count         = hs_count_q;
    assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_udt_rx_handshake_filter.sv
// tb_udt_rx_handshake_filter
// Directed and randomized frames against a frame-level reference model that
// predicts the handshake stream, the data stream and both counters.

module tb_udt_rx_handshake_filter;

    localparam int HS_BEATS = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    logic             clk;
    logic             core_rst_n;
    logic [63:0]      s_tdata;
    logic [7:0]       s_tkeep;
    logic             s_tvalid;
    logic             s_tlast;
    logic             s_tready;
    logic [63:0]      handshake_tdata;
    logic [7:0]       handshake_tkeep;
    logic             handshake_tvalid;
    logic             handshake_tlast;
    logic             handshake_tready;
    logic [63:0]      data_tdata;
    logic [7:0]       data_tkeep;
    logic             data_tvalid;
    logic             data_tlast;
    logic             data_tready;
    logic [CNT_W-1:0] hs_count;
    logic [CNT_W-1:0] drop_count;

    int    checks   = 0;
    int    failures = 0;
    int    readyMode = 0;
    bit    trackReady = 0;
    int    expHsCnt = 0;
    int    expDropCnt = 0;
    beat_t txFrame[$];
    beat_t expHs[$];
    beat_t expData[$];
    beat_t hsGot[$];
    beat_t dataGot[$];

    udt_rx_handshake_filter #(
        .HS_BEATS(HS_BEATS),
        .CNT_W   (CNT_W)
    ) dut (
        .clk             (clk),
        .core_rst_n      (core_rst_n),
        .s_tdata         (s_tdata),
        .s_tkeep         (s_tkeep),
        .s_tvalid        (s_tvalid),
        .s_tlast         (s_tlast),
        .s_tready        (s_tready),
        .handshake_tdata (handshake_tdata),
        .handshake_tkeep (handshake_tkeep),
        .handshake_tvalid(handshake_tvalid),
        .handshake_tlast (handshake_tlast),
        .handshake_tready(handshake_tready),
        .data_tdata      (data_tdata),
        .data_tkeep      (data_tkeep),
        .data_tvalid     (data_tvalid),
        .data_tlast      (data_tlast),
        .data_tready     (data_tready),
        .hs_count        (hs_count),
        .drop_count      (drop_count)
    );

    // Free-running core clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=time limit reached required=completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reportTimeout(input string tag);
        checks++;
        failures++;
        $display("[TB] FAIL %s: observed=timeout required=progress", tag);
    endtask

    // Downstream ready patterns, changed just after each rising edge.
    initial begin
        handshake_tready = 1'b1;
        data_tready      = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: begin handshake_tready = 1'b1; data_tready = 1'b1; end
                1: begin handshake_tready = 1'b1; data_tready = ~data_tready; end
                2: begin
                    handshake_tready = 1'($urandom_range(0, 1));
                    data_tready      = 1'($urandom_range(0, 1));
                end
                default: begin handshake_tready = 1'b0; data_tready = 1'b1; end
            endcase
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (core_rst_n === 1'b1) begin
                if (handshake_tvalid && handshake_tready)
                    hsGot.push_back({handshake_tlast, handshake_tkeep, handshake_tdata});
                if (data_tvalid && data_tready)
                    dataGot.push_back({data_tlast, data_tkeep, data_tdata});
                if (trackReady)
                    checkOutput("s_tready_track", 80'(s_tready), 80'(!data_tvalid || data_tready));
            end
        end
    end

    function automatic logic [63:0] randHs();
        return {1'b1, 15'h0000, 16'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [63:0] randData();
        return {1'b0, 31'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [63:0] randCtrlNonHs();
        return {1'b1, 15'($urandom_range(1, 32767)), 16'($urandom), 32'($urandom)};
    endfunction

    // Build a frame; badKeepBeat is a 0-based beat index given keep 7F (-1 for none).
    task automatic buildFrame(input logic [63:0] word0, input int nBeats,
                              input int badKeepBeat, input logic [7:0] lastKeep);
        beat_t b;
        txFrame.delete();
        for (int i = 0; i < nBeats; i++) begin
            b.data = (i == 0) ? word0 : {$urandom, $urandom};
            b.keep = (i == nBeats - 1) ? lastKeep : 8'hFF;
            if (i == badKeepBeat) b.keep = 8'h7F;
            b.last = (i == nBeats - 1);
            txFrame.push_back(b);
        end
    endtask

    // Frame-level reference: predicts what the frame produces downstream.
    task automatic modelFrame();
        bit    isHs;
        bit    allFull;
        beat_t e;
        isHs = txFrame[0].data[63] && (txFrame[0].data[62:48] == 15'h0000);
        if (isHs) begin
            allFull = 1;
            foreach (txFrame[i]) if (txFrame[i].keep != 8'hFF) allFull = 0;
            if (txFrame.size() == HS_BEATS && allFull) begin
                foreach (txFrame[i]) begin
                    e.data = txFrame[i].data;
                    e.keep = 8'hFF;
                    e.last = (i == HS_BEATS - 1);
                    expHs.push_back(e);
                end
                expHsCnt = (expHsCnt < CNT_MAX) ? expHsCnt + 1 : CNT_MAX;
            end else begin
                expDropCnt = (expDropCnt < CNT_MAX) ? expDropCnt + 1 : CNT_MAX;
            end
        end else begin
            foreach (txFrame[i]) expData.push_back(txFrame[i]);
        end
    endtask

    // Present one beat and return just after the edge that accepts it.
    task automatic sendBeat(input beat_t b, output int waited);
        bit done;
        done     = 0;
        waited   = 0;
        s_tvalid = 1'b1;
        s_tdata  = b.data;
        s_tkeep  = b.keep;
        s_tlast  = b.last;
        while (!done && waited < 1000) begin
            @(negedge clk);
            if (s_tready === 1'b1) done = 1;
            else waited++;
            @(posedge clk);
            #1;
        end
        if (!done) reportTimeout("s_tready_wait");
    endtask

    task automatic applyStimulus(input bit allowGaps);
        int w;
        modelFrame();
        foreach (txFrame[i]) begin
            if (allowGaps && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            sendBeat(txFrame[i], w);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drainAndCompare(input string tag);
        int budget;
        budget = 0;
        while ((hsGot.size() < expHs.size() || dataGot.size() < expData.size()) && budget < 3000) begin
            @(posedge clk);
            budget++;
        end
        if (budget >= 3000) reportTimeout({tag, "_drain"});
        repeat (6) @(posedge clk);
        #1;
        checkOutput({tag, "_hs_beats"}, 80'(hsGot.size()), 80'(expHs.size()));
        checkOutput({tag, "_data_beats"}, 80'(dataGot.size()), 80'(expData.size()));
        for (int i = 0; i < expHs.size() && i < hsGot.size(); i++)
            checkOutput({tag, "_hs_beat"}, 80'(hsGot[i]), 80'(expHs[i]));
        for (int i = 0; i < expData.size() && i < dataGot.size(); i++)
            checkOutput({tag, "_data_beat"}, 80'(dataGot[i]), 80'(expData[i]));
        checkOutput({tag, "_hs_count"}, 80'(hs_count), 80'(expHsCnt));
        checkOutput({tag, "_drop_count"}, 80'(drop_count), 80'(expDropCnt));
        hsGot.delete();
        dataGot.delete();
        expHs.delete();
        expData.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_s_tready"}, 80'(s_tready), 80'(0));
        checkOutput({tag, "_hs_tvalid"}, 80'(handshake_tvalid), 80'(0));
        checkOutput({tag, "_hs_tlast"}, 80'(handshake_tlast), 80'(0));
        checkOutput({tag, "_hs_tdata"}, 80'(handshake_tdata), 80'(0));
        checkOutput({tag, "_hs_tkeep"}, 80'(handshake_tkeep), 80'(0));
        checkOutput({tag, "_data_tvalid"}, 80'(data_tvalid), 80'(0));
        checkOutput({tag, "_data_tlast"}, 80'(data_tlast), 80'(0));
        checkOutput({tag, "_data_tdata"}, 80'(data_tdata), 80'(0));
        checkOutput({tag, "_data_tkeep"}, 80'(data_tkeep), 80'(0));
        checkOutput({tag, "_hs_count"}, 80'(hs_count), 80'(0));
        checkOutput({tag, "_drop_count"}, 80'(drop_count), 80'(0));
    endtask

    initial begin
        int          w;
        int          kind;
        logic [63:0] word0;

        core_rst_n = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tkeep    = '0;
        s_tlast    = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        core_rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_s_tready", 80'(s_tready), 80'(1));

        // Legal handshake with fixed first word; latency of one cycle.
        buildFrame(64'h8000_0000_0000_0000, HS_BEATS, -1, 8'hFF);
        applyStimulus(0);
        checkOutput("hs_latency_valid", 80'(handshake_tvalid), 80'(1));
        checkOutput("hs_latency_data", 80'(handshake_tdata), 80'(64'h8000_0000_0000_0000));
        checkOutput("hs_latency_keep", 80'(handshake_tkeep), 80'(8'hFF));
        checkOutput("hs_latency_last", 80'(handshake_tlast), 80'(0));
        drainAndCompare("legal");

        // Three-beat data packet under toggling data_tready.
        readyMode  = 1;
        trackReady = 1;
        buildFrame(randData(), 3, -1, 8'h0F);
        applyStimulus(0);
        drainAndCompare("data");
        trackReady = 0;
        readyMode  = 0;

        // Short handshake followed by a legal one.
        buildFrame(randHs(), 5, -1, 8'hFF);
        applyStimulus(0);
        buildFrame(randHs(), HS_BEATS, -1, 8'hFF);
        applyStimulus(0);
        drainAndCompare("short");

        // Oversize handshake: drop counted at beat 8, beats 9..12 taken without stall.
        buildFrame(randHs(), 12, -1, 8'hFF);
        modelFrame();
        for (int i = 0; i < 12; i++) begin
            sendBeat(txFrame[i], w);
            if (i == HS_BEATS - 2)
                checkOutput("oversize_before_8", 80'(drop_count), 80'(expDropCnt - 1));
            if (i == HS_BEATS - 1)
                checkOutput("oversize_drop_at_8", 80'(drop_count), 80'(expDropCnt));
            if (i >= HS_BEATS)
                checkOutput("oversize_no_stall", 80'(w), 80'(0));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        drainAndCompare("oversize");

        // Bad keep on beat 4, then a single-beat handshake.
        buildFrame(randHs(), HS_BEATS, 3, 8'hFF);
        applyStimulus(1);
        buildFrame(randHs(), 1, -1, 8'hFF);
        applyStimulus(1);
        drainAndCompare("keep_single");

        // Randomized mix of frame kinds with random readies and input gaps.
        readyMode = 2;
        repeat (40) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                0: buildFrame(randHs(), HS_BEATS, -1, 8'hFF);
                1: buildFrame(randHs(), int'($urandom_range(1, HS_BEATS - 1)), -1, 8'hFF);
                2: buildFrame(randHs(), int'($urandom_range(HS_BEATS + 1, HS_BEATS + 3)), -1, 8'hFF);
                3: buildFrame(randHs(), HS_BEATS, int'($urandom_range(0, HS_BEATS - 1)), 8'hFF);
                4: buildFrame(randData(), int'($urandom_range(1, 6)), -1, 8'($urandom_range(1, 255)));
                default: buildFrame(randCtrlNonHs(), int'($urandom_range(1, 6)), -1, 8'($urandom_range(1, 255)));
            endcase
            applyStimulus(1);
        end
        drainAndCompare("random");
        readyMode = 0;

        // Push both counters past all-ones.
        repeat (CNT_MAX + 3) begin
            buildFrame(randHs(), 1, -1, 8'hFF);
            applyStimulus(0);
        end
        repeat (CNT_MAX + 2) begin
            buildFrame(randHs(), HS_BEATS, -1, 8'hFF);
            applyStimulus(0);
        end
        drainAndCompare("saturate");
        checkOutput("drop_saturated", 80'(drop_count), 80'(CNT_MAX));
        checkOutput("hs_saturated", 80'(hs_count), 80'(CNT_MAX));

        // Replay held off for 10 cycles, then reset mid-replay.
        readyMode = 3;
        @(posedge clk);
        #1;
        buildFrame(randHs(), HS_BEATS, -1, 8'hFF);
        word0 = txFrame[0].data;
        applyStimulus(0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_hs_tvalid", 80'(handshake_tvalid), 80'(1));
            checkOutput("bp_hs_tdata", 80'(handshake_tdata), 80'(word0));
            checkOutput("bp_s_tready", 80'(s_tready), 80'(0));
            @(posedge clk);
            #1;
        end
        core_rst_n = 1'b0;
        #1;
        checkAllZero("mid_emit_reset");
        @(posedge clk);
        #1;
        core_rst_n = 1'b1;
        hsGot.delete();
        dataGot.delete();
        expHs.delete();
        expData.delete();
        expHsCnt   = 0;
        expDropCnt = 0;
        readyMode  = 0;

        // Normal operation resumes after reset.
        @(posedge clk);
        #1;
        buildFrame(randHs(), HS_BEATS, -1, 8'hFF);
        applyStimulus(0);
        drainAndCompare("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
